// File: rtl/id_ex_stage.sv
// LC-3b ID/EX pipeline register: operand forwarding, load-use bubble insertion,
// memory-stall hold, branch squash and a saturating load-use bubble counter.

module id_ex_fwd_mux #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] rf_data,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [WIDTH-1:0] ex_result,
    output logic [WIDTH-1:0] op
);
    // 2'b11 is reserved and falls back to the register file.
    always_comb begin
        op = rf_data;
        case (sel)
            2'b01:   op = mem_result;
            2'b10:   op = ex_result;
            default: op = rf_data;
        endcase
    end
endmodule

module id_ex_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic             id_imm_mode,
    input  logic [2:0]       id_dest,
    input  logic             id_regwrite,
    input  logic [WIDTH-1:0] id_sr1_data,
    input  logic [WIDTH-1:0] id_sr2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic [WIDTH-1:0] ex_result,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [3:0]       ex_opcode,
    output logic             ex_imm_mode,
    output logic [2:0]       ex_dest,
    output logic             ex_regwrite,
    output logic [WIDTH-1:0] ex_op_a,
    output logic [WIDTH-1:0] ex_op_b,
    output logic [WIDTH-1:0] ex_imm,
    output logic [CNT_W-1:0] stall_count
);
    localparam int NUM_OPS = 2;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;

    logic [NUM_OPS-1:0][1:0]       sel;
    logic [NUM_OPS-1:0][WIDTH-1:0] rf_data;
    logic [NUM_OPS-1:0][WIDTH-1:0] fwd_data;
    logic                          ex_is_load;
    logic                          load_use;

    assign sel     = {fwd_sel_b, fwd_sel_a};
    assign rf_data = {id_sr2_data, id_sr1_data};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        id_ex_fwd_mux #(.WIDTH(WIDTH)) u_mux (
            .sel        (sel[i]),
            .rf_data    (rf_data[i]),
            .mem_result (mem_result),
            .ex_result  (ex_result),
            .op         (fwd_data[i])
        );
    end

    // A load in EX has no data yet, so any consumer selecting ex_result must wait.
    assign ex_is_load = (ex_opcode == OP_LDR) || (ex_opcode == OP_LDB) || (ex_opcode == OP_LDI);
    assign load_use   = id_valid && ex_valid && ex_is_load &&
                        ((fwd_sel_a == 2'b10) || (fwd_sel_b == 2'b10));
    assign id_stall   = reset_n && !flush && (mem_stall || load_use);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_imm_mode <= 1'b0;
            ex_dest     <= '0;
            ex_regwrite <= 1'b0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_imm      <= '0;
            stall_count <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
        end else if (mem_stall) begin
            // whole pipeline holds; load_use is re-evaluated once the stall drops
        end else if (load_use) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_opcode   <= id_opcode;
            ex_imm_mode <= id_imm_mode;
            ex_dest     <= id_dest;
            ex_regwrite <= id_regwrite && id_valid;
            ex_op_a     <= fwd_data[0];
            ex_op_b     <= fwd_data[1];
            ex_imm      <= id_imm;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a narrow counter keeps the
// saturation scenario short.

module tb_id_ex_stage;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDR = 4'b0110;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic             id_imm_mode;
    logic [2:0]       id_dest;
    logic             id_regwrite;
    logic [WIDTH-1:0] id_sr1_data, id_sr2_data, id_imm;
    logic [1:0]       fwd_sel_a, fwd_sel_b;
    logic [WIDTH-1:0] ex_result, mem_result;
    logic             mem_stall, flush;
    logic             id_stall, ex_valid, ex_imm_mode, ex_regwrite;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_dest;
    logic [WIDTH-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [CNT_W-1:0] stall_count;

    int nchk = 0;
    int nerr = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_imm_mode(id_imm_mode), .id_dest(id_dest), .id_regwrite(id_regwrite),
        .id_sr1_data(id_sr1_data), .id_sr2_data(id_sr2_data), .id_imm(id_imm),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_result(ex_result),
        .mem_result(mem_result), .mem_stall(mem_stall), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_imm_mode(ex_imm_mode), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb);
        id_valid    = 1'b1;
        id_opcode   = op;
        id_regwrite = 1'b1;
        fwd_sel_a   = sa;
        fwd_sel_b   = sb;
    endtask

    // Puts a valid LDR into EX (no hazard: selects are regfile).
    task automatic load_ldr(input logic [WIDTH-1:0] a);
        set_id(OP_LDR, 2'b00, 2'b00);
        id_sr1_data = a;
        mem_stall   = 1'b0;
        flush       = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_stall = 1'b1; flush = 1'b0;
        set_id(OP_LDR, 2'b10, 2'b10);
        id_imm_mode = 1'b1; id_dest = 3'd7; id_sr1_data = 16'h1111; id_sr2_data = 16'h2222;
        id_imm = 16'h3333; ex_result = 16'h4444; mem_result = 16'h5555;
        #1;
        nchk++; if (id_stall !== 1'b0) begin nerr++; $display("FAIL reset_id_stall got %b exp 0", id_stall); end
        step();
        step();
        nchk++; if (ex_valid !== 1'b0) begin nerr++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
        nchk++; if ({ex_op_a, ex_op_b, ex_imm} !== 48'h0) begin nerr++; $display("FAIL reset_data got %h exp 0", {ex_op_a, ex_op_b, ex_imm}); end
        nchk++; if (stall_count !== 8'h00) begin nerr++; $display("FAIL reset_count got %h exp 00", stall_count); end
        mem_stall = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_forward();
        set_id(OP_ADD, 2'b10, 2'b01);
        id_dest = 3'd1; id_imm_mode = 1'b0; id_imm = 16'h0005;
        id_sr1_data = 16'h0002; id_sr2_data = 16'h0003;
        ex_result = 16'h1234; mem_result = 16'hBEEF;
        #1;
        nchk++; if (id_stall !== 1'b0) begin nerr++; $display("FAIL fwd_id_stall got %b exp 0", id_stall); end
        step();
        nchk++; if (ex_op_a !== 16'h1234) begin nerr++; $display("FAIL fwd_op_a got %h exp 1234", ex_op_a); end
        nchk++; if (ex_op_b !== 16'hBEEF) begin nerr++; $display("FAIL fwd_op_b got %h exp beef", ex_op_b); end
        nchk++; if ({ex_valid, ex_regwrite, ex_opcode, ex_dest, ex_imm} !== {1'b1, 1'b1, OP_ADD, 3'd1, 16'h0005})
            begin nerr++; $display("FAIL fwd_fields got %b%b %h %h %h exp 11 1 1 0005", ex_valid, ex_regwrite, ex_opcode, ex_dest, ex_imm); end
        // invalid ID instruction must not produce a regwrite
        id_valid = 1'b0;
        step();
        nchk++; if ({ex_valid, ex_regwrite} !== 2'b00) begin nerr++; $display("FAIL fwd_invalid got %b%b exp 00", ex_valid, ex_regwrite); end
    endtask

    task automatic test_load_use();
        load_ldr(16'h0040);
        set_id(OP_ADD, 2'b10, 2'b00);
        ex_result = 16'hDEAD;
        #1;
        nchk++; if (id_stall !== 1'b1) begin nerr++; $display("FAIL lu_id_stall got %b exp 1", id_stall); end
        step();
        exp_cnt++;
        nchk++; if ({ex_valid, ex_regwrite} !== 2'b00) begin nerr++; $display("FAIL lu_bubble got %b%b exp 00", ex_valid, ex_regwrite); end
        nchk++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL lu_count got %h exp %h", stall_count, exp_cnt); end
        nchk++; if (id_stall !== 1'b0) begin nerr++; $display("FAIL lu_release got %b exp 0", id_stall); end
        fwd_sel_a = 2'b01; mem_result = 16'h00FF;
        step();
        nchk++; if ({ex_valid, ex_op_a} !== {1'b1, 16'h00FF}) begin nerr++; $display("FAIL lu_retry got %b %h exp 1 00ff", ex_valid, ex_op_a); end
    endtask

    task automatic test_mem_stall();
        load_ldr(16'hAAAA);
        // ID changes and is also a load-use consumer; the hold must win
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(OP_ADD, 2'b10, 2'b01);
            id_sr1_data = 16'h1000 + 16'(i); id_imm = 16'h7000 + 16'(i); id_dest = 3'(i);
            #1;
            nchk++; if (id_stall !== 1'b1) begin nerr++; $display("FAIL hold_id_stall[%0d] got %b exp 1", i, id_stall); end
            step();
            nchk++; if ({ex_valid, ex_opcode, ex_op_a} !== {1'b1, OP_LDR, 16'hAAAA})
                begin nerr++; $display("FAIL hold_regs[%0d] got %b %h %h exp 1 6 aaaa", i, ex_valid, ex_opcode, ex_op_a); end
            nchk++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL hold_count[%0d] got %h exp %h", i, stall_count, exp_cnt); end
        end
        mem_stall = 1'b0;
        #1;
        nchk++; if (id_stall !== 1'b1) begin nerr++; $display("FAIL hold_then_lu got %b exp 1", id_stall); end
        step();
        exp_cnt++;
        nchk++; if ({ex_valid, stall_count} !== {1'b0, exp_cnt}) begin nerr++; $display("FAIL hold_then_bubble got %b %h exp 0 %h", ex_valid, stall_count, exp_cnt); end
    endtask

    task automatic test_flush();
        load_ldr(16'h0101);
        set_id(OP_ADD, 2'b10, 2'b10);
        mem_stall = 1'b1; flush = 1'b1;
        #1;
        nchk++; if (id_stall !== 1'b0) begin nerr++; $display("FAIL flush_id_stall got %b exp 0", id_stall); end
        step();
        nchk++; if ({ex_valid, ex_regwrite} !== 2'b00) begin nerr++; $display("FAIL flush_squash got %b%b exp 00", ex_valid, ex_regwrite); end
        nchk++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL flush_count got %h exp %h", stall_count, exp_cnt); end
        mem_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reserved_sel();
        set_id(OP_ADD, 2'b00, 2'b11);
        id_sr1_data = 16'h0F0F; id_sr2_data = 16'h5A5A;
        ex_result = 16'h1111; mem_result = 16'h2222;
        step();
        nchk++; if (ex_op_b !== 16'h5A5A) begin nerr++; $display("FAIL rsv_op_b got %h exp 5a5a", ex_op_b); end
        nchk++; if (ex_op_a !== 16'h0F0F) begin nerr++; $display("FAIL rsv_op_a got %h exp 0f0f", ex_op_a); end
    endtask

    task automatic test_saturation();
        while (exp_cnt != 8'hFF) begin
            load_ldr(16'h0000);
            set_id(OP_ADD, 2'b00, 2'b10);
            step();
            exp_cnt++;
        end
        nchk++; if (stall_count !== 8'hFF) begin nerr++; $display("FAIL sat_reach got %h exp ff", stall_count); end
        load_ldr(16'h0000);
        set_id(OP_ADD, 2'b10, 2'b00);
        #1;
        nchk++; if (id_stall !== 1'b1) begin nerr++; $display("FAIL sat_id_stall got %b exp 1", id_stall); end
        step();
        nchk++; if ({ex_valid, stall_count} !== {1'b0, 8'hFF}) begin nerr++; $display("FAIL sat_hold got %b %h exp 0 ff", ex_valid, stall_count); end
    endtask

    task automatic test_reset_mid_stall();
        load_ldr(16'h9999);
        set_id(OP_ADD, 2'b10, 2'b10);
        mem_stall = 1'b1;
        reset_n = 1'b0;
        #1;
        nchk++; if (id_stall !== 1'b0) begin nerr++; $display("FAIL rmid_id_stall got %b exp 0", id_stall); end
        step();
        nchk++; if ({ex_valid, ex_regwrite, ex_opcode, ex_dest, ex_imm_mode, ex_op_a, ex_op_b, ex_imm} !== '0)
            begin nerr++; $display("FAIL rmid_outputs got %b%b %h %h %b %h %h %h exp all 0", ex_valid, ex_regwrite, ex_opcode, ex_dest, ex_imm_mode, ex_op_a, ex_op_b, ex_imm); end
        nchk++; if (stall_count !== 8'h00) begin nerr++; $display("FAIL rmid_count got %h exp 00", stall_count); end
        mem_stall = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_stall();
        test_flush();
        test_reserved_sel();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the LC-3b pipeline. It applies the operand-forwarding selects produced by the forwarding units and latches the forwarded operands into EX. It detects load-use hazards, stalls ID for one cycle and inserts a bubble into EX. It also honours the global memory-stall hold and branch flush, and keeps a saturating count of load-use bubbles.

## Interface
Parameters:
- WIDTH, 16, datapath width of operands and immediates
- CNT_W, 16, width of the stall_count performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  lc3b_opcode of ID instruction
- id_imm_mode  in  1  instruction bit 5 (immediate form)
- id_dest  in  3  destination register
- id_regwrite  in  1  ID instruction writes the register file
- id_sr1_data, id_sr2_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate/offset
- fwd_sel_a, fwd_sel_b  in  2  forwarding selects for SR1/SR2, computed on ID fields against EX/MEM destinations
- ex_result  in  WIDTH  ALU result of the instruction currently in EX
- mem_result  in  WIDTH  writeback value of the instruction currently in MEM
- mem_stall  in  1  data/instruction memory busy; whole pipeline holds
- flush  in  1  taken branch resolved; squash younger instructions
- id_stall  out  1  hold IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_opcode  out  4  registered opcode
- ex_imm_mode  out  1  registered imm_mode
- ex_dest  out  3  registered destination
- ex_regwrite  out  1  registered regwrite, forced 0 when ex_valid=0
- ex_op_a, ex_op_b  out  WIDTH  registered, forwarded operands
- ex_imm  out  WIDTH  registered immediate
- stall_count  out  CNT_W  number of load-use bubbles inserted

## Operation
- Forwarding mux, per operand: sel 2'b00 → regfile data; 2'b01 → mem_result; 2'b10 → ex_result; 2'b11 (reserved) → regfile data.
- Load-use hazard:
  - load_use = id_valid & ex_valid & (ex_opcode ∈ {op_ldr, op_ldb, op_ldi}) & (fwd_sel_a==2'b10 | fwd_sel_b==2'b10).
  - ex_result is not valid data for a load in EX, so ID waits one cycle.
  - On the retry cycle the load is in MEM and the select becomes 2'b01.
- Per-edge update priority, highest first:
  1. !reset_n → all outputs 0, stall_count 0.
  2. flush → ex_valid 0, ex_regwrite 0; other fields don't-care (held); overrides mem_stall.
  3. mem_stall → every register holds.
  4. load_use → bubble: ex_valid 0, ex_regwrite 0; stall_count +1, saturating at all-ones.
  5. Otherwise → capture: ex_valid ← id_valid, ex_regwrite ← id_regwrite & id_valid, all ID fields and muxed operands latched.
- id_stall = reset_n & !flush & (mem_stall | load_use).
- ex_opcode, ex_dest and ex_imm may carry stale values while ex_valid=0; consumers gate on ex_valid/ex_regwrite.
- Effective states:
  - RUN (capture)
  - HOLD (mem_stall)
  - BUBBLE (load_use)
  - SQUASH (flush)
  - Selected every cycle by the priority above; no multi-cycle state beyond the registers. Back-to-back load-use for the same consumer cannot occur, because the load leaves EX after one bubble.

## Timing
- Latency ID→EX: 1 cycle when not stalled.
- load_use: exactly 1 bubble cycle; id_stall high for that cycle only, unless mem_stall extends it.
- mem_stall concurrent with load_use: HOLD wins. No bubble and no count increment; load_use is re-evaluated after mem_stall drops.
- flush concurrent with load_use or mem_stall: SQUASH; id_stall low; counter unchanged.
- Reset mid-operation: next edge clears everything regardless of other inputs; id_stall low while reset_n=0.
- Counter at all-ones stays all-ones on further bubbles.

## Test plan
- Plain forward:
  - Stimulus: ID ADD R1,R2,R3; fwd_sel_a=2'b10, fwd_sel_b=2'b01; ex_result=16'h1234, mem_result=16'hBEEF.
  - Required response: next edge ex_op_a=16'h1234, ex_op_b=16'hBEEF, ex_valid=1.
- Load-use:
  - Stimulus: EX holds LDR (ex_valid=1); ID ADD with fwd_sel_a=2'b10.
  - Required response: id_stall=1; next edge ex_valid=0, stall_count=1.
  - Next cycle: fwd_sel_a=2'b01, mem_result=16'h00FF → ex_op_a=16'h00FF, ex_valid=1.
- mem_stall hold:
  - Stimulus: ex_op_a=16'hAAAA; assert mem_stall 3 cycles while ID inputs change.
  - Required response: outputs unchanged for 3 cycles; id_stall=1 each cycle; stall_count unchanged.
- Flush priority:
  - Stimulus: flush=1 together with mem_stall=1 and load_use.
  - Required response: next edge ex_valid=0, ex_regwrite=0; id_stall=0; stall_count unchanged.
- Reserved select / saturation:
  - Stimulus: fwd_sel_b=2'b11, id_sr2_data=16'h5A5A.
  - Required response: ex_op_b=16'h5A5A.
  - Stimulus: preload stall_count to 16'hFFFF via bubbles, then one more load-use.
  - Required response: stall_count remains 16'hFFFF.
- Reset mid-stall:
  - Stimulus: reset_n=0 during mem_stall.
  - Required response: next edge all outputs 0, stall_count=0.
